game_screen_ctrl: RTL and testbench

Top-level screen sequencer for boxhead. It tracks game phase (START, PLAYING, PAUSED, GAMEOVER) from keyboard and death events. It gates gameplay logic and pulses a world reset on each new game. It owns the shared overlay sprite ROM, selecting the title, pause or game-over image, and generates a registered overlay address for the color mapper.

---
 rtl/game_pkg.sv | 40 ++++
 rtl/overlay_window.sv | 43 ++++
 rtl/game_screen_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_game_screen_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the boxhead screen sequencer:
//   - state_e       : game phase encoding (matches the game_state output code)
//   - KEY_SPACE/P   : HID keycodes used for start and pause
//   - overlay sprite geometry (size, screen centre, packed-ROM base) for the
//     title, pause and game-over images
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        ST_START    = 2'b00,
        ST_PLAYING  = 2'b01,
        ST_PAUSED   = 2'b10,
        ST_GAMEOVER = 2'b11
    } state_e;

    localparam logic [7:0] KEY_SPACE = 8'd44;
    localparam logic [7:0] KEY_P     = 8'd19;

    // All three images live back to back in one row-major ROM.
    localparam int unsigned TITLE_W    = 180;
    localparam int unsigned TITLE_H    = 30;
    localparam int unsigned TITLE_CX   = 160;
    localparam int unsigned TITLE_CY   = 80;
    localparam int unsigned TITLE_BASE = 0;

    localparam int unsigned PAUSE_W    = 120;
    localparam int unsigned PAUSE_H    = 30;
    localparam int unsigned PAUSE_CX   = 160;
    localparam int unsigned PAUSE_CY   = 120;
    localparam int unsigned PAUSE_BASE = 5400;

    localparam int unsigned GOVER_W    = 180;
    localparam int unsigned GOVER_H    = 30;
    localparam int unsigned GOVER_CX   = 160;
    localparam int unsigned GOVER_CY   = 120;
    localparam int unsigned GOVER_BASE = 9000;

endpackage

// File: rtl/overlay_window.sv
// ---------------------------------------------------------------------------
// overlay_window
// Combinational hit test and ROM address for one rectangular sprite.
// Ports:
//   px_i, py_i  in  9   current pixel coordinate
//   hit_o       out 1   pixel lies inside [X0,X0+W) x [Y0,Y0+H)
//   addr_o      out 18  BASE + (py-Y0)*W + (px-X0); meaningful only on hit
// ---------------------------------------------------------------------------
module overlay_window #(
    parameter int unsigned X0   = 0,
    parameter int unsigned Y0   = 0,
    parameter int unsigned W    = 1,
    parameter int unsigned H    = 1,
    parameter int unsigned BASE = 0
) (
    input  logic [8:0]  px_i,
    input  logic [8:0]  py_i,
    output logic        hit_o,
    output logic [17:0] addr_o
);

    localparam logic [17:0] X0_L   = 18'(X0);
    localparam logic [17:0] X1_L   = 18'(X0 + W);
    localparam logic [17:0] Y0_L   = 18'(Y0);
    localparam logic [17:0] Y1_L   = 18'(Y0 + H);
    localparam logic [17:0] W_L    = 18'(W);
    localparam logic [17:0] BASE_L = 18'(BASE);

    logic [17:0] px;
    logic [17:0] py;
    logic [17:0] dx;
    logic [17:0] dy;

    assign px = {9'd0, px_i};
    assign py = {9'd0, py_i};
    // Offsets wrap when outside the window; harmless because hit_o gates use.
    assign dx = px - X0_L;
    assign dy = py - Y0_L;

    assign hit_o  = (px >= X0_L) && (px < X1_L) && (py >= Y0_L) && (py < Y1_L);
    assign addr_o = BASE_L + dy * W_L + dx;

endmodule

// File: rtl/game_screen_ctrl.sv
// ---------------------------------------------------------------------------
// game_screen_ctrl
// Screen sequencer: START -> PLAYING <-> PAUSED, PLAYING -> GAMEOVER -> START.
// Gates gameplay (Game_Run), pulses Game_Reset on each new game and drives a
// registered overlay address into the shared title/pause/game-over ROM.
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   keycode     in  8       current key (0 = none); events on key press edge
//   frame_tick  in  1       one-cycle pulse per frame
//   player_dead in  1       level, player health reached zero
//   PixelX/Y    in  9       current pixel coordinate
//   game_state  out 2       00 START, 01 PLAYING, 10 PAUSED, 11 GAMEOVER
//   Game_Run    out 1       high only while PLAYING
//   Game_Reset  out 1       one-cycle pulse on START->PLAYING
//   is_obj      out 1       overlay pixel valid (1-cycle latency)
//   Obj_address out 18      overlay ROM address (0 when no hit)
// Optional build macro GAMESTART_BLINK_EN: blink the title in START with a
// half-period of BLINK_FRAMES frames.
// ---------------------------------------------------------------------------
module game_screen_ctrl
    import game_pkg::*;
#(
    parameter int unsigned FRAME_W         = 9,
    parameter int unsigned GAMEOVER_FRAMES = 180,
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter logic [7:0]  KEY_START       = KEY_SPACE,
    parameter logic [7:0]  KEY_PAUSE       = KEY_P
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  keycode,
    input  logic        frame_tick,
    input  logic        player_dead,
    input  logic [8:0]  PixelX,
    input  logic [8:0]  PixelY,
    output logic [1:0]  game_state,
    output logic        Game_Run,
    output logic        Game_Reset,
    output logic        is_obj,
    output logic [17:0] Obj_address
);

    localparam logic [FRAME_W-1:0] GO_LAST = FRAME_W'(GAMEOVER_FRAMES - 1);

    state_e             state_q;
    logic               run_q;
    logic               greset_q;
    logic [7:0]         key_prev_q;
    logic [FRAME_W-1:0] go_cnt_q;
    logic               start_evt;
    logic               pause_evt;

    // A held key fires only on the cycle it first appears.
    assign start_evt = (keycode == KEY_START) && (key_prev_q != KEY_START);
    assign pause_evt = (keycode == KEY_PAUSE) && (key_prev_q != KEY_PAUSE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_START;
            run_q      <= 1'b0;
            greset_q   <= 1'b0;
            key_prev_q <= 8'd0;
            go_cnt_q   <= '0;
        end else begin
            key_prev_q <= keycode;
            greset_q   <= 1'b0;
            case (state_q)
                ST_START: begin
                    if (start_evt) begin
                        state_q  <= ST_PLAYING;
                        run_q    <= 1'b1;
                        greset_q <= 1'b1;
                    end
                end
                ST_PLAYING: begin
                    // Death wins over a simultaneous pause press.
                    if (player_dead) begin
                        state_q  <= ST_GAMEOVER;
                        run_q    <= 1'b0;
                        go_cnt_q <= '0;
                    end else if (pause_evt) begin
                        state_q <= ST_PAUSED;
                        run_q   <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (pause_evt || start_evt) begin
                        state_q <= ST_PLAYING;
                        run_q   <= 1'b1;
                    end
                end
                ST_GAMEOVER: begin
                    if (start_evt) begin
                        state_q <= ST_START;
                    end else if (frame_tick) begin
                        if (go_cnt_q == GO_LAST) begin
                            state_q <= ST_START;
                        end else begin
                            go_cnt_q <= go_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_START;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign game_state = state_q;
    assign Game_Run   = run_q;
    assign Game_Reset = greset_q;

    // ------------------------------------------------------------------
    // Title visibility
    // ------------------------------------------------------------------
    logic title_vis;

`ifdef GAMESTART_BLINK_EN
    localparam logic [FRAME_W-1:0] BLINK_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [FRAME_W-1:0] blink_cnt_q;
    logic               blink_vis_q;

    // Held at its restart value outside START so entry always shows the title.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
        end else if (state_q != ST_START) begin
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_vis_q <= ~blink_vis_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign title_vis = blink_vis_q;
`else
    assign title_vis = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Overlay windows and registered select
    // ------------------------------------------------------------------
    logic        title_hit, pause_hit, gover_hit;
    logic [17:0] title_addr, pause_addr, gover_addr;

    overlay_window #(
        .X0(TITLE_CX - TITLE_W / 2), .Y0(TITLE_CY - TITLE_H / 2),
        .W(TITLE_W), .H(TITLE_H), .BASE(TITLE_BASE)
    ) u_title (
        .px_i(PixelX), .py_i(PixelY), .hit_o(title_hit), .addr_o(title_addr)
    );

    overlay_window #(
        .X0(PAUSE_CX - PAUSE_W / 2), .Y0(PAUSE_CY - PAUSE_H / 2),
        .W(PAUSE_W), .H(PAUSE_H), .BASE(PAUSE_BASE)
    ) u_pause (
        .px_i(PixelX), .py_i(PixelY), .hit_o(pause_hit), .addr_o(pause_addr)
    );

    overlay_window #(
        .X0(GOVER_CX - GOVER_W / 2), .Y0(GOVER_CY - GOVER_H / 2),
        .W(GOVER_W), .H(GOVER_H), .BASE(GOVER_BASE)
    ) u_gover (
        .px_i(PixelX), .py_i(PixelY), .hit_o(gover_hit), .addr_o(gover_addr)
    );

    logic        obj_d, obj_q;
    logic [17:0] addr_d, addr_q;

    always_comb begin
        obj_d  = 1'b0;
        addr_d = 18'd0;
        case (state_q)
            ST_START: begin
                if (title_hit && title_vis) begin
                    obj_d  = 1'b1;
                    addr_d = title_addr;
                end
            end
            ST_PAUSED: begin
                if (pause_hit) begin
                    obj_d  = 1'b1;
                    addr_d = pause_addr;
                end
            end
            ST_GAMEOVER: begin
                if (gover_hit) begin
                    obj_d  = 1'b1;
                    addr_d = gover_addr;
                end
            end
            default: begin
                obj_d  = 1'b0;
                addr_d = 18'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            obj_q  <= 1'b0;
            addr_q <= 18'd0;
        end else begin
            obj_q  <= obj_d;
            addr_q <= addr_d;
        end
    end

    assign is_obj      = obj_q;
    assign Obj_address = addr_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_screen_ctrl
// Directed stimulus for game_screen_ctrl. A phase/overlay model tracks what
// the outputs must be every cycle; literal expectations pin key points.
// ---------------------------------------------------------------------------
module tb_game_screen_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [7:0]  keycode = 8'd0;
    logic        frame_tick = 1'b0;
    logic        player_dead = 1'b0;
    logic [8:0]  PixelX = 9'd0;
    logic [8:0]  PixelY = 9'd0;
    logic [1:0]  game_state;
    logic        Game_Run;
    logic        Game_Reset;
    logic        is_obj;
    logic [17:0] Obj_address;

    game_screen_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_tick(frame_tick),
        .player_dead(player_dead), .PixelX(PixelX), .PixelY(PixelY),
        .game_state(game_state), .Game_Run(Game_Run), .Game_Reset(Game_Reset),
        .is_obj(is_obj), .Obj_address(Obj_address)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Phase codes: 0 START, 1 PLAYING, 2 PAUSED, 3 GAMEOVER.
    int m_state = 0;
    int m_prev  = 0;
    int m_ticks = 0;
    bit m_reset = 1'b0;
    bit m_obj   = 1'b0;
    int m_addr  = 0;
    bit se_m, pe_m, h_m;
    int a_m;

    // Which image a phase shows, where it sits and where it starts in ROM.
    function automatic void exp_overlay(input int st, input int x, input int y,
                                        output bit hit, output int addr);
        int w, h, cx, cy, base, x0, y0;
        hit = 1'b0; addr = 0;
        w = 0; h = 0; cx = 0; cy = 0; base = 0;
        case (st)
            0: begin w = 180; h = 30; cx = 160; cy = 80;  base = 0;    end
            2: begin w = 120; h = 30; cx = 160; cy = 120; base = 5400; end
            3: begin w = 180; h = 30; cx = 160; cy = 120; base = 9000; end
            default: return;
        endcase
        x0 = cx - w / 2;
        y0 = cy - h / 2;
        if (x >= x0 && x < x0 + w && y >= y0 && y < y0 + h) begin
            hit  = 1'b1;
            addr = base + (y - y0) * w + (x - x0);
        end
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_state = 0; m_prev = 0; m_ticks = 0;
            m_reset = 1'b0; m_obj = 1'b0; m_addr = 0;
        end else begin
            exp_overlay(m_state, int'(PixelX), int'(PixelY), h_m, a_m);
            m_obj  = h_m;
            m_addr = a_m;
            se_m = (keycode == 8'd44) && (m_prev != 44);
            pe_m = (keycode == 8'd19) && (m_prev != 19);
            m_prev  = int'(keycode);
            m_reset = 1'b0;
            case (m_state)
                0: if (se_m) begin m_state = 1; m_reset = 1'b1; end
                1: begin
                    if (player_dead) begin m_state = 3; m_ticks = 0; end
                    else if (pe_m) m_state = 2;
                end
                2: if (pe_m || se_m) m_state = 1;
                default: begin
                    if (se_m) m_state = 0;
                    else if (frame_tick) begin
                        m_ticks++;
                        if (m_ticks == 180) m_state = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("m_state", int'(game_state), m_state);
            check("m_run", int'(Game_Run), (m_state == 1) ? 1 : 0);
            check("m_greset", int'(Game_Reset), int'(m_reset));
            check("m_obj", int'(is_obj), int'(m_obj));
            check("m_addr", int'(Obj_address), m_addr);
        end
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic press(input logic [7:0] k);
        keycode = 8'd0;
        tick();
        keycode = k;
        tick();
    endtask

    initial begin
        // Reset state with the pixel sitting on the title
        PixelX = 9'd70; PixelY = 9'd65;
        tick(); tick();
        check("rst_state", int'(game_state), 0);
        check("rst_run", int'(Game_Run), 0);
        check("rst_greset", int'(Game_Reset), 0);
        check("rst_obj", int'(is_obj), 0);
        check("rst_addr", int'(Obj_address), 0);
        Reset_n = 1'b1;
        chk_en  = 1'b1;

        // Title window corners
        tick();
        check("title_tl_obj", int'(is_obj), 1);
        check("title_tl_addr", int'(Obj_address), 0);
        PixelX = 9'd249; PixelY = 9'd94;
        tick();
        check("title_br_addr", int'(Obj_address), 5399);
        PixelX = 9'd250;
        tick();
        check("title_right_edge", int'(is_obj), 0);
        PixelX = 9'd69; PixelY = 9'd65;
        tick();
        check("title_left_edge", int'(is_obj), 0);

        // Start game, hold SPACE
        keycode = 8'd44;
        tick();
        check("start_state", int'(game_state), 1);
        check("start_greset", int'(Game_Reset), 1);
        check("start_run", int'(Game_Run), 1);
        tick();
        check("greset_once", int'(Game_Reset), 0);
        repeat (100) tick();
        check("hold_space_state", int'(game_state), 1);

        // Pause, pause overlay, held P, unpause
        keycode = 8'd19;
        tick();
        check("pause_state", int'(game_state), 2);
        check("pause_run", int'(Game_Run), 0);
        PixelX = 9'd100; PixelY = 9'd105;
        tick();
        check("pause_addr", int'(Obj_address), 5400);
        repeat (5) tick();
        check("hold_p_state", int'(game_state), 2);
        press(8'd19);
        check("unpause_state", int'(game_state), 1);
        check("unpause_greset", int'(Game_Reset), 0);

        // Death ignored while paused; SPACE resumes
        press(8'd19);
        player_dead = 1'b1;
        tick(); tick();
        check("paused_dead_ignored", int'(game_state), 2);
        player_dead = 1'b0;
        keycode = 8'd44;
        tick();
        check("space_resume", int'(game_state), 1);
        check("space_resume_greset", int'(Game_Reset), 0);

        // Death beats pause in the same cycle
        keycode = 8'd0;
        tick();
        keycode = 8'd19; player_dead = 1'b1;
        tick();
        check("dead_over_pause", int'(game_state), 3);
        player_dead = 1'b0; keycode = 8'd0;
        tick();
        check("gover_obj", int'(is_obj), 1);
        check("gover_addr", int'(Obj_address), 9030);

        // Auto-return after 180 frames
        for (int i = 1; i <= 180; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            if (i == 179) check("gover_179", int'(game_state), 3);
            if (i == 180) check("gover_180", int'(game_state), 0);
            tick();
        end

        // New game, die, leave GAMEOVER early with SPACE
        keycode = 8'd44;
        tick();
        check("restart_greset", int'(Game_Reset), 1);
        keycode = 8'd0; player_dead = 1'b1;
        tick();
        player_dead = 1'b0;
        for (int i = 0; i < 10; i++) begin
            frame_tick = 1'b1; tick();
            frame_tick = 1'b0; tick();
        end
        check("gover_10_ticks", int'(game_state), 3);
        keycode = 8'd44;
        tick();
        check("space_exit_state", int'(game_state), 0);
        check("space_exit_greset", int'(Game_Reset), 0);
        tick();
        check("space_held_no_start", int'(game_state), 0);

        // Asynchronous reset mid-PLAYING
        press(8'd44);
        keycode = 8'd0;
        PixelX = 9'd70; PixelY = 9'd65;
        tick();
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_state", int'(game_state), 0);
        check("async_rst_run", int'(Game_Run), 0);
        check("async_rst_obj", int'(is_obj), 0);
        tick();
        Reset_n = 1'b1;
        tick();
        check("post_rst_title", int'(is_obj), 1);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
